// File: rtl/binary_frame_ctrl.sv
// binary_frame_ctrl
//   Frame-level controller for the CbCr -> gray -> binary pipeline. Delays the
//   sync/enable strobes by PIPE_LAT so they line up with data_binary, gates the
//   returned pixel with the delayed enable, and owns the pipeline threshold.
//   Threshold changes (cfg valid/ready write or thr_up/thr_dn pulses) are parked
//   in a pending register and only committed outside active video.
// Ports:
//   clk, rst_n                 pixel clock, async active-low reset
//   pre_frame_vsync/hsync/de   front-end strobes aligned with data_cbcr
//   data_binary                pixel returned from the pipeline
//   cfg_valid/cfg_thr/cfg_ready absolute threshold write handshake
//   thr_up/thr_dn              single-step threshold adjust pulses
//   threshold                  threshold driven to the pipeline
//   post_frame_vsync/hsync/de  strobes delayed by PIPE_LAT
//   post_data                  data_binary gated by post_frame_de
//   frame_done                 pulse on the falling edge of post_frame_vsync
//   white_cnt                  white pixels in the last frame (BIN_WHITE_CNT_EN only)
// Optional feature macro: BIN_WHITE_CNT_EN
module binary_frame_ctrl #(
  parameter int unsigned PIPE_LAT = 8,
  parameter logic [7:0]  THR_INIT = 8'd128,
  parameter logic [7:0]  THR_STEP = 8'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pre_frame_vsync,
  input  logic        pre_frame_hsync,
  input  logic        pre_frame_de,
  input  logic [7:0]  data_binary,
  input  logic        cfg_valid,
  input  logic [7:0]  cfg_thr,
  output logic        cfg_ready,
  input  logic        thr_up,
  input  logic        thr_dn,
  output logic [7:0]  threshold,
  output logic        post_frame_vsync,
  output logic        post_frame_hsync,
  output logic        post_frame_de,
  output logic [7:0]  post_data,
  output logic        frame_done
`ifdef BIN_WHITE_CNT_EN
  ,
  output logic [19:0] white_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_ACTIVE} state_t;

  state_t      state, state_nxt;
  logic [PIPE_LAT-1:0] vs_sr, hs_sr, de_sr;
  logic        vs_d, post_vs_d;
  logic        vs_rise, vs_fall;
  logic [7:0]  pend_thr, pend_thr_nxt;
  logic        pend_v, pend_v_nxt;
  logic [7:0]  thr_nxt;
  logic [7:0]  base;
  logic [8:0]  up_sum;
  logic        commit, accept;

  // Strobe delay lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_sr <= '0;
      hs_sr <= '0;
      de_sr <= '0;
    end else begin
      vs_sr[0] <= pre_frame_vsync;
      hs_sr[0] <= pre_frame_hsync;
      de_sr[0] <= pre_frame_de;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        vs_sr[i] <= vs_sr[i-1];
        hs_sr[i] <= hs_sr[i-1];
        de_sr[i] <= de_sr[i-1];
      end
    end
  end

  assign post_frame_vsync = vs_sr[PIPE_LAT-1];
  assign post_frame_hsync = hs_sr[PIPE_LAT-1];
  assign post_frame_de    = de_sr[PIPE_LAT-1];
  assign post_data        = post_frame_de ? data_binary : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d      <= 1'b0;
      post_vs_d <= 1'b0;
    end else begin
      vs_d      <= pre_frame_vsync;
      post_vs_d <= post_frame_vsync;
    end
  end

  assign vs_rise    = pre_frame_vsync & ~vs_d;
  assign vs_fall    = ~pre_frame_vsync & vs_d;
  assign frame_done = post_vs_d & ~post_frame_vsync;

  // Next-state, pending register and threshold commit
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (vs_rise) state_nxt = S_BLANK;
      S_BLANK:  if (vs_fall) state_nxt = S_ACTIVE;
      S_ACTIVE: if (vs_rise) state_nxt = S_BLANK;
      default:  state_nxt = S_IDLE;
    endcase

    commit  = pend_v && (state != S_ACTIVE);
    accept  = cfg_valid && cfg_ready;
    base    = pend_v ? pend_thr : threshold;
    up_sum  = {1'b0, base} + {1'b0, THR_STEP};
    thr_nxt = commit ? pend_thr : threshold;

    pend_thr_nxt = pend_thr;
    pend_v_nxt   = pend_v && !commit;
    if (accept) begin
      pend_thr_nxt = cfg_thr;
      pend_v_nxt   = 1'b1;
    end else if (thr_up && !thr_dn) begin
      pend_thr_nxt = up_sum[8] ? 8'hff : up_sum[7:0];
      pend_v_nxt   = 1'b1;
    end else if (thr_dn && !thr_up) begin
      pend_thr_nxt = (base < THR_STEP) ? 8'h00 : base - THR_STEP;
      pend_v_nxt   = 1'b1;
    end
  end

  // cfg_ready is registered from next-cycle values so it reads 0 while in reset
  // and otherwise equals !pend_v || state == S_BLANK for the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      threshold <= THR_INIT;
      pend_thr  <= '0;
      pend_v    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      threshold <= thr_nxt;
      pend_thr  <= pend_thr_nxt;
      pend_v    <= pend_v_nxt;
      cfg_ready <= !pend_v_nxt || (state_nxt == S_BLANK);
    end
  end

`ifdef BIN_WHITE_CNT_EN
  logic [19:0] white_acc, white_sum;

  always_comb begin
    white_sum = white_acc;
    if (post_frame_de && (data_binary == 8'hff) && (white_acc != '1))
      white_sum = white_acc + 20'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      white_acc <= '0;
      white_cnt <= '0;
    end else if (frame_done) begin
      white_cnt <= white_sum;
      white_acc <= '0;
    end else begin
      white_acc <= white_sum;
    end
  end
`endif

endmodule

// File: tb/tb_binary_frame_ctrl.sv
module tb_binary_frame_ctrl;

  logic        clk;
  logic        rst_n;
  logic        pre_frame_vsync, pre_frame_hsync, pre_frame_de;
  logic [7:0]  data_binary;
  logic        cfg_valid;
  logic [7:0]  cfg_thr;
  logic        cfg_ready;
  logic        thr_up, thr_dn;
  logic [7:0]  threshold;
  logic        post_frame_vsync, post_frame_hsync, post_frame_de;
  logic [7:0]  post_data;
  logic        frame_done;
  logic [19:0] white_cnt;

  int checks;
  int failures;

  binary_frame_ctrl #(
    .PIPE_LAT(8),
    .THR_INIT(8'd128),
    .THR_STEP(8'd4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pre_frame_vsync(pre_frame_vsync),
    .pre_frame_hsync(pre_frame_hsync),
    .pre_frame_de(pre_frame_de),
    .data_binary(data_binary),
    .cfg_valid(cfg_valid),
    .cfg_thr(cfg_thr),
    .cfg_ready(cfg_ready),
    .thr_up(thr_up),
    .thr_dn(thr_dn),
    .threshold(threshold),
    .post_frame_vsync(post_frame_vsync),
    .post_frame_hsync(post_frame_hsync),
    .post_frame_de(post_frame_de),
    .post_data(post_data),
    .frame_done(frame_done)
`ifdef BIN_WHITE_CNT_EN
    ,
    .white_cnt(white_cnt)
`endif
  );

`ifndef BIN_WHITE_CNT_EN
  assign white_cnt = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pre_frame_vsync = 1'b0;
    pre_frame_hsync = 1'b0;
    pre_frame_de    = 1'b0;
    data_binary     = 8'h00;
    cfg_valid       = 1'b0;
    cfg_thr         = 8'h00;
    thr_up          = 1'b0;
    thr_dn          = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    data_binary = 8'hff;
    step();
    step();
    checks++; if (threshold !== 8'd128) begin failures++; $display("FAIL reset_thr: got %0d expected 128", threshold); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", cfg_ready); end
    checks++; if ({post_frame_vsync, post_frame_hsync, post_frame_de} !== 3'b000) begin failures++; $display("FAIL reset_post: got %b expected 000", {post_frame_vsync, post_frame_hsync, post_frame_de}); end
    checks++; if (post_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", post_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", frame_done); end
    checks++; if (white_cnt !== 20'd0) begin failures++; $display("FAIL reset_white: got %0d expected 0", white_cnt); end
    rst_n = 1'b1;
    step();
  endtask

  // de high for 640 cycles, hsync high for 3: both must reappear 8 cycles later.
  task automatic test_latency();
    logic exp_de, exp_hs;
    int   de_cnt;
    int   first_de;
    data_binary = 8'hff;
    de_cnt = 0;
    first_de = -1;
    for (int j = 0; j <= 700; j++) begin
      exp_de = (j >= 8) && (j <= 647);
      exp_hs = (j >= 8) && (j <= 10);
      if (post_frame_de === 1'b1) begin
        de_cnt++;
        if (first_de < 0) first_de = j;
      end
      checks++; if (post_frame_de !== exp_de) begin failures++; $display("FAIL lat_de@%0d: got %b expected %b", j, post_frame_de, exp_de); end
      checks++; if (post_frame_hsync !== exp_hs) begin failures++; $display("FAIL lat_hs@%0d: got %b expected %b", j, post_frame_hsync, exp_hs); end
      checks++; if (post_data !== (exp_de ? 8'hff : 8'h00)) begin failures++; $display("FAIL lat_data@%0d: got %h expected %h", j, post_data, exp_de ? 8'hff : 8'h00); end
      pre_frame_de    = (j < 640);
      pre_frame_hsync = (j < 3);
      step();
    end
    checks++; if (first_de != 8) begin failures++; $display("FAIL lat_first: got %0d expected 8", first_de); end
    checks++; if (de_cnt != 640) begin failures++; $display("FAIL lat_len: got %0d expected 640", de_cnt); end
    clear_inputs();
  endtask

  task automatic test_idle_commit();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_ready0: got %b expected 1", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_thr   = 8'd100;
    step();
    cfg_valid = 1'b0;
    checks++; if (threshold !== 8'd128) begin failures++; $display("FAIL idle_thr_early: got %0d expected 128", threshold); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL idle_ready1: got %b expected 0", cfg_ready); end
    step();
    checks++; if (threshold !== 8'd100) begin failures++; $display("FAIL idle_thr: got %0d expected 100", threshold); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL idle_ready2: got %b expected 1", cfg_ready); end
  endtask

  // vsync high 5 cycles: post_vsync high at steps 8..12, frame_done at step 13 only.
  task automatic test_frame_done();
    for (int j = 0; j <= 20; j++) begin
      checks++; if (post_frame_vsync !== ((j >= 8) && (j <= 12))) begin failures++; $display("FAIL fd_vs@%0d: got %b", j, post_frame_vsync); end
      checks++; if (frame_done !== (j == 13)) begin failures++; $display("FAIL fd_pulse@%0d: got %b expected %b", j, frame_done, (j == 13)); end
      pre_frame_vsync = (j < 5);
      step();
    end
    pre_frame_vsync = 1'b0;
  endtask

  task automatic test_deferred_cfg();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL def_ready: got %b expected 1", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_thr   = 8'd90;
    step();
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (threshold !== 8'd128) begin failures++; $display("FAIL def_hold@%0d: got %0d expected 128", i, threshold); end
      step();
    end
    pre_frame_vsync = 1'b1;
    step();
    checks++; if (threshold !== 8'd128) begin failures++; $display("FAIL def_entry: got %0d expected 128", threshold); end
    step();
    checks++; if (threshold !== 8'd90) begin failures++; $display("FAIL def_apply: got %0d expected 90", threshold); end
  endtask

  task automatic test_saturation();
    logic [7:0] prev;
    int         exp;
    cfg_valid = 1'b1;
    cfg_thr   = 8'd252;
    step();
    cfg_valid = 1'b0;
    step();
    checks++; if (threshold !== 8'd252) begin failures++; $display("FAIL sat_load: got %0d expected 252", threshold); end
    for (int k = 0; k < 3; k++) begin
      thr_up = 1'b1;
      step();
      thr_up = 1'b0;
      step();
      checks++; if (threshold !== 8'd255) begin failures++; $display("FAIL sat_up%0d: got %0d expected 255", k, threshold); end
    end
    prev = threshold;
    for (int k = 1; k <= 65; k++) begin
      thr_dn = 1'b1;
      step();
      thr_dn = 1'b0;
      step();
      exp = (255 >= 4 * k) ? 255 - 4 * k : 0;
      checks++; if (threshold !== 8'(exp)) begin failures++; $display("FAIL sat_dn%0d: got %0d expected %0d", k, threshold, exp); end
      checks++; if (threshold > prev) begin failures++; $display("FAIL sat_wrap%0d: got %0d after %0d", k, threshold, prev); end
      prev = threshold;
    end
  endtask

  task automatic test_collision();
    cfg_valid = 1'b1;
    cfg_thr   = 8'd50;
    thr_up    = 1'b1;
    step();
    cfg_valid = 1'b0;
    thr_up    = 1'b0;
    step();
    checks++; if (threshold !== 8'd50) begin failures++; $display("FAIL col_cfg_up: got %0d expected 50", threshold); end
    thr_up = 1'b1;
    thr_dn = 1'b1;
    step();
    thr_up = 1'b0;
    thr_dn = 1'b0;
    step();
    checks++; if (threshold !== 8'd50) begin failures++; $display("FAIL col_up_dn: got %0d expected 50", threshold); end
    step();
    checks++; if (threshold !== 8'd50) begin failures++; $display("FAIL col_up_dn2: got %0d expected 50", threshold); end
  endtask

  task automatic test_backpressure();
    pre_frame_vsync = 1'b0;
    step();
    step();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0: got %b expected 1", cfg_ready); end
    cfg_valid = 1'b1;
    cfg_thr   = 8'd70;
    step();
    cfg_thr = 8'd80;
    for (int i = 0; i < 4; i++) begin
      checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL bp_stall@%0d: got %b expected 0", i, cfg_ready); end
      checks++; if (threshold !== 8'd50) begin failures++; $display("FAIL bp_hold@%0d: got %0d expected 50", i, threshold); end
      step();
    end
    pre_frame_vsync = 1'b1;
    step();
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL bp_blank_ready: got %b expected 1", cfg_ready); end
    checks++; if (threshold !== 8'd50) begin failures++; $display("FAIL bp_entry: got %0d expected 50", threshold); end
    step();
    cfg_valid = 1'b0;
    checks++; if (threshold !== 8'd70) begin failures++; $display("FAIL bp_first: got %0d expected 70", threshold); end
    step();
    checks++; if (threshold !== 8'd80) begin failures++; $display("FAIL bp_last: got %0d expected 80", threshold); end
  endtask

`ifdef BIN_WHITE_CNT_EN
  // 100 de pixels reach the output at steps 28..127; 37 of them (28..64) are white.
  // data_binary is also 8'hff outside de to confirm only enabled pixels count.
  task automatic test_white_cnt();
    bit found;
    for (int j = 0; j < 140; j++) begin
      pre_frame_vsync = 1'b0;
      pre_frame_de    = (j >= 20) && (j < 120);
      data_binary     = ((j < 28) || (j <= 64) || (j >= 128)) ? 8'hff : 8'h00;
      step();
    end
    clear_inputs();
    pre_frame_vsync = 1'b1;
    repeat (3) step();
    pre_frame_vsync = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_done === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin failures++; $display("FAIL wc_done: got no frame_done within 40 cycles"); end
    step();
    checks++; if (white_cnt !== 20'd37) begin failures++; $display("FAIL wc_count: got %0d expected 37", white_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    clear_inputs();
    step();
    step();
    cfg_valid = 1'b1;
    cfg_thr   = 8'd200;
    step();
    cfg_valid    = 1'b0;
    pre_frame_de = 1'b1;
    data_binary  = 8'hff;
    repeat (12) step();
    checks++; if (threshold !== 8'd80) begin failures++; $display("FAIL rm_active_hold: got %0d expected 80", threshold); end
    rst_n = 1'b0;
    #1;
    checks++; if (threshold !== 8'd128) begin failures++; $display("FAIL rm_thr: got %0d expected 128", threshold); end
    checks++; if (post_frame_de !== 1'b0) begin failures++; $display("FAIL rm_de: got %b expected 0", post_frame_de); end
    checks++; if (post_data !== 8'h00) begin failures++; $display("FAIL rm_data: got %h expected 00", post_data); end
    checks++; if (cfg_ready !== 1'b0) begin failures++; $display("FAIL rm_ready: got %b expected 0", cfg_ready); end
    checks++; if (white_cnt !== 20'd0) begin failures++; $display("FAIL rm_white: got %0d expected 0", white_cnt); end
    clear_inputs();
    step();
    rst_n = 1'b1;
    step();
    pre_frame_vsync = 1'b1;
    repeat (4) step();
    checks++; if (threshold !== 8'd128) begin failures++; $display("FAIL rm_pending_lost: got %0d expected 128", threshold); end
    pre_frame_vsync = 1'b0;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_latency();
    test_idle_commit();
    do_reset();
    test_frame_done();
    test_deferred_cfg();
    test_saturation();
    test_collision();
    test_backpressure();
`ifdef BIN_WHITE_CNT_EN
    test_white_cnt();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
